// File: rtl/mul_pkg.sv
// mul_pkg: shared classification types and exponent constants for the multiplier front end
package mul_pkg;
    localparam int EXPO_W_DEF = 8;
    localparam int MANT_W_DEF = 23;
    localparam int ZERO_D_DEF = 6;
    localparam int CLS_NAN  = 3;
    localparam int CLS_SNAN = 2;
    localparam int CLS_INF  = 1;
    localparam int CLS_ZERO = 0;
    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
    } fp_cls_t;
    function automatic int expo_all1(input int ew);
        return (1 << ew) - 1;
    endfunction
    function automatic int expo_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
    localparam int EXPO_ALL1 = expo_all1(EXPO_W_DEF);
    localparam int EXPO_BIAS = expo_bias(EXPO_W_DEF);
endpackage

// File: rtl/mul_lzc.sv
// mul_lzc: leading-zero count, returns W when the input is all zero
module mul_lzc #(
    parameter int W  = 24,
    parameter int ZW = 6
) (
    input  logic [W-1:0]  d,
    output logic [ZW-1:0] lz
);
    always_comb begin
        lz = ZW'(W);
        for (int k = 0; k < W; k++)
            if (d[k]) lz = ZW'(W - 1 - k);
    end
endmodule

// File: rtl/mul_operand_prenorm.sv
// mul_operand_prenorm: unpack, classify and prenormalize two IEEE operands for the multiplier
module mul_operand_prenorm
    import mul_pkg::*;
#(
    parameter int EXPO_W = EXPO_W_DEF,
    parameter int MANT_W = MANT_W_DEF,
    parameter int ZERO_D = ZERO_D_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXPO_W+MANT_W:0]   opa,
    input  logic [EXPO_W+MANT_W:0]   opb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sign_o,
    output logic [EXPO_W+1:0]        expo_a_o,
    output logic [EXPO_W+1:0]        expo_b_o,
    output logic [MANT_W:0]          mant_a_o,
    output logic [MANT_W:0]          mant_b_o,
    output logic [3:0]               cls_a_o,
    output logic [3:0]               cls_b_o,
    output logic                     invalid_o
);
    localparam int OW = EXPO_W + MANT_W + 1;
    localparam int XW = EXPO_W + 2;
    localparam int MW = MANT_W + 1;
    localparam logic [EXPO_W-1:0] ALL1 = EXPO_W'(expo_all1(EXPO_W));
    logic              s1_v, s2_v, s1_adv, s1_ld;
    logic              s1_sign, s2_sign, s2_inv, inv_d;
    logic [OW-1:0]     op      [2];
    logic [EXPO_W-1:0] e_d     [2];
    logic [EXPO_W-1:0] s1_e    [2];
    logic [MANT_W-1:0] f_d     [2];
    logic [MANT_W-1:0] s1_f    [2];
    fp_cls_t           cls_d   [2];
    fp_cls_t           s1_cls  [2];
    fp_cls_t           s2_cls  [2];
    logic              sub_d   [2];
    logic              s1_sub  [2];
    logic [ZERO_D-1:0] lz_d    [2];
    logic [ZERO_D-1:0] s1_lz   [2];
    logic [XW-1:0]     expo_d  [2];
    logic [XW-1:0]     s2_expo [2];
    logic [MW-1:0]     mant_d  [2];
    logic [MW-1:0]     s2_mant [2];
    assign s1_adv   = !s2_v | out_ready;
    assign in_ready = !s1_v | s1_adv;
    assign s1_ld    = in_valid & in_ready;
    assign op[0]    = opa;
    assign op[1]    = opb;
    genvar i;
    for (i = 0; i < 2; i++) begin : g_op
        assign e_d[i]   = op[i][MANT_W +: EXPO_W];
        assign f_d[i]   = op[i][MANT_W-1:0];
        assign cls_d[i] = {(e_d[i] == ALL1) & (|f_d[i]),
                           (e_d[i] == ALL1) & (|f_d[i]) & !f_d[i][MANT_W-1],
                           (e_d[i] == ALL1) & !(|f_d[i]),
                           !(|e_d[i]) & !(|f_d[i])};
        assign sub_d[i] = !(|e_d[i]) & (|f_d[i]);
        mul_lzc #(.W(MW), .ZW(ZERO_D)) u_lzc (
            .d  ({1'b0, f_d[i]}),
            .lz (lz_d[i])
        );
        // subnormals are shifted up to an explicit leading 1 and the exponent is debited to match
        assign mant_d[i] = s1_cls[i].zero ? '0 :
                           s1_sub[i] ? MW'({1'b0, s1_f[i]} << s1_lz[i]) : {1'b1, s1_f[i]};
        assign expo_d[i] = s1_cls[i].zero ? '0 :
                           s1_sub[i] ? XW'(1) - XW'(s1_lz[i]) : XW'(s1_e[i]);
    end
    assign inv_d = s1_cls[0].snan | s1_cls[1].snan |
                   (s1_cls[0].inf & s1_cls[1].zero) | (s1_cls[0].zero & s1_cls[1].inf);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_sign <= 1'b0;
            s2_sign <= 1'b0;
            s2_inv  <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                s1_e[k]    <= '0;
                s1_f[k]    <= '0;
                s1_cls[k]  <= '0;
                s1_sub[k]  <= 1'b0;
                s1_lz[k]   <= '0;
                s2_cls[k]  <= '0;
                s2_expo[k] <= '0;
                s2_mant[k] <= '0;
            end
        end else begin
            if (in_ready) s1_v <= in_valid;
            if (s1_adv) s2_v <= s1_v;
            if (s1_ld) begin
                s1_sign <= opa[OW-1] ^ opb[OW-1];
                for (int k = 0; k < 2; k++) begin
                    s1_e[k]   <= e_d[k];
                    s1_f[k]   <= f_d[k];
                    s1_cls[k] <= cls_d[k];
                    s1_sub[k] <= sub_d[k];
                    s1_lz[k]  <= lz_d[k];
                end
            end
            if (s1_v & s1_adv) begin
                s2_sign <= s1_sign;
                s2_inv  <= inv_d;
                for (int k = 0; k < 2; k++) begin
                    s2_cls[k]  <= s1_cls[k];
                    s2_expo[k] <= expo_d[k];
                    s2_mant[k] <= mant_d[k];
                end
            end
        end
    end
    assign out_valid = s2_v;
    assign sign_o    = s2_sign;
    assign invalid_o = s2_inv;
    assign expo_a_o  = s2_expo[0];
    assign expo_b_o  = s2_expo[1];
    assign mant_a_o  = s2_mant[0];
    assign mant_b_o  = s2_mant[1];
    assign cls_a_o   = s2_cls[0];
    assign cls_b_o   = s2_cls[1];
endmodule
